// File: rtl/regfile_mp.sv
// Multi-port integer register file with x0 hardwired to zero, a per-register busy scoreboard and a
// post-reset clear engine. Define REGFILE_BYPASS_EN to forward same-cycle write data to read ports.
module regfile_mp #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int NUM_READ  = 2,
  parameter int NUM_WRITE = 2,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_READ*AW-1:0]    rd_addr,
  output logic [NUM_READ*XLEN-1:0]  rd_data,
  output logic [NUM_READ-1:0]       rd_busy,
  input  logic [NUM_WRITE-1:0]      wr_en,
  input  logic [NUM_WRITE*AW-1:0]   wr_addr,
  input  logic [NUM_WRITE*XLEN-1:0] wr_data,
  input  logic                      alloc_en,
  input  logic [AW-1:0]             alloc_addr,
  output logic                      init_done
);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_nx;
  logic [AW-1:0]    clr_idx;
  logic [XLEN-1:0]  mem [NREGS];
  logic [NREGS-1:0] busy;
  logic             clr_last;

  assign clr_last = (clr_idx == AW'(NREGS - 1));

  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= CLEAR;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    if (state == CLEAR && clr_last) state_nx = RUN;
  end

  always_comb init_done = (state == RUN);

  // clr_idx parks on its terminal value instead of wrapping
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      clr_idx <= '0;
      busy    <= '0;
    end else if (state == CLEAR) begin
      if (!clr_last) clr_idx <= clr_idx + AW'(1);
    end else begin
      for (int w = 0; w < NUM_WRITE; w++)
        if (wr_en[w] && wr_addr[w*AW +: AW] != '0) busy[wr_addr[w*AW +: AW]] <= 1'b0;
      if (alloc_en && alloc_addr != '0) busy[alloc_addr] <= 1'b1;
    end

  // Later loop iterations override earlier ones: highest-numbered port wins
  always_ff @(posedge clock)
    if (state == CLEAR) mem[clr_idx] <= '0;
    else
      for (int w = 0; w < NUM_WRITE; w++)
        if (wr_en[w] && wr_addr[w*AW +: AW] != '0) mem[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];

  for (genvar r = 0; r < NUM_READ; r++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] d;
    logic            b;

    assign ra = rd_addr[r*AW +: AW];

    always_comb begin
      d = '0;
      b = 1'b0;
      if (state == RUN && ra != '0) begin
        d = mem[ra];
        b = busy[ra];
`ifdef REGFILE_BYPASS_EN
        for (int w = 0; w < NUM_WRITE; w++)
          if (wr_en[w] && wr_addr[w*AW +: AW] == ra) begin
            d = wr_data[w*XLEN +: XLEN];
            b = alloc_en && (alloc_addr == ra);
          end
`endif
      end
    end

    assign rd_data[r*XLEN +: XLEN] = d;
    assign rd_busy[r]              = b;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a reference model predicts read results per cycle, expectations are
// queued on drive and popped/compared once the combinational outputs settle.
module tb_regfile_mp;
  localparam int XLEN = 32, NREGS = 32, NR = 2, NW = 2, AW = 5;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [NR*AW-1:0]     rd_addr;
  logic [NR*XLEN-1:0]   rd_data;
  logic [NR-1:0]        rd_busy;
  logic [NW-1:0]        wr_en;
  logic [NW*AW-1:0]     wr_addr;
  logic [NW*XLEN-1:0]   wr_data;
  logic                 alloc_en;
  logic [AW-1:0]        alloc_addr;
  logic                 init_done;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NUM_READ(NR), .NUM_WRITE(NW)) dut (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_en(alloc_en),
    .alloc_addr(alloc_addr), .init_done(init_done));

  always #5 clock = ~clock;

  typedef struct {
    string           tag;
    int              port;
    logic [XLEN-1:0] data;
    logic            busy;
    logic            done;
  } exp_t;

  exp_t            sb[$];
  int              n_chk = 0, n_fail = 0;
  logic [XLEN-1:0] m_mem [NREGS];
  logic            m_busy [NREGS];
  int              clr_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREGS; i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end
    clr_cnt = 0;
  endtask

  task automatic set_rst(input logic v);
    reset = v;
    if (!v) model_clear();
  endtask

  task automatic drive(input logic [NW-1:0] we, input logic [AW-1:0] wa0, input logic [XLEN-1:0] wd0,
                       input logic [AW-1:0] wa1, input logic [XLEN-1:0] wd1,
                       input logic ae, input logic [AW-1:0] aa,
                       input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    wr_en = we; wr_addr = {wa1, wa0}; wr_data = {wd1, wd0};
    alloc_en = ae; alloc_addr = aa; rd_addr = {ra1, ra0};
  endtask

  // One cycle: predict, push, settle, pop/compare, clock edge, advance model.
  task automatic step(input string tag);
    logic            run;
    logic [AW-1:0]   a, wa;
    exp_t            e;
    run = (clr_cnt == NREGS);
    for (int p = 0; p < NR; p++) begin
      a = rd_addr[p*AW +: AW];
      e.tag = tag; e.port = p; e.data = '0; e.busy = 1'b0; e.done = run;
      if (run && a != 0) begin
        e.data = m_mem[a]; e.busy = m_busy[a];
`ifdef REGFILE_BYPASS_EN
        for (int w = 0; w < NW; w++) begin
          wa = wr_addr[w*AW +: AW];
          if (wr_en[w] && wa == a) begin
            e.data = wr_data[w*XLEN +: XLEN];
            e.busy = alloc_en && alloc_addr == a;
          end
        end
`endif
      end
      sb.push_back(e);
    end
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, "/data"}, 64'(rd_data[e.port*XLEN +: XLEN]), 64'(e.data));
      chk({e.tag, "/busy"}, 64'(rd_busy[e.port]), 64'(e.busy));
      if (e.port == 0) chk({e.tag, "/init_done"}, 64'(init_done), 64'(e.done));
    end
    @(posedge clock);
    if (!reset) model_clear();
    else if (run) begin
      for (int w = 0; w < NW; w++) begin
        wa = wr_addr[w*AW +: AW];
        if (wr_en[w] && wa != 0) begin m_mem[wa] = wr_data[w*XLEN +: XLEN]; m_busy[wa] = 1'b0; end
      end
      if (alloc_en && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
    end else clr_cnt++;
    @(negedge clock);
  endtask

  task automatic run_clear(input string tag);
    for (int c = 0; c < NREGS; c++) begin
      // Writes/allocs during clear must be dropped
      drive(2'b11, 5'd5, 32'hFFFF_FFFF, 5'(c), 32'h5555_0000 + c, 1'b1, 5'd5, 5'(c), 5'd5);
      step(tag);
    end
  endtask

  initial begin
    model_clear();
    set_rst(1'b0);
    drive('0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    step("reset");
    step("reset_hold");
    set_rst(1'b1);
    run_clear("clear");

    drive('0, 0, 0, 0, 0, 0, 0, 5'd5, 5'd31);
    step("post_clear");
    drive(2'b01, 5'd5, 32'hDEAD_BEEF, 0, 0, 0, 0, 5'd5, 5'd0);
    step("wr_x5");
    drive(2'b10, 0, 0, 5'd0, 32'h1234, 0, 0, 5'd5, 5'd0);
    step("rd_x5_wr_x0");
    drive('0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd5);
    step("rd_x0");
    drive(2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 0, 0, 5'd7, 5'd7);
    step("wr_x7_both");
    drive('0, 0, 0, 0, 0, 0, 0, 5'd7, 5'd7);
    step("rd_x7");
    drive('0, 0, 0, 0, 0, 1'b1, 5'd3, 5'd3, 5'd0);
    step("alloc_x3");
    drive('0, 0, 0, 0, 0, 1'b1, 5'd3, 5'd3, 5'd3);
    step("realloc_x3");
    drive(2'b01, 5'd3, 32'h33, 0, 0, 0, 0, 5'd3, 5'd3);
    step("wr_x3");
    drive(2'b10, 0, 0, 5'd3, 32'h44, 1'b1, 5'd3, 5'd3, 5'd0);
    step("alloc_wr_x3");
    drive('0, 0, 0, 0, 0, 1'b1, 5'd0, 5'd3, 5'd0);
    step("alloc_x0");
    drive(2'b01, 5'd9, 32'hA5, 0, 0, 0, 0, 5'd9, 5'd3);
    step("bypass_x9");
    drive(2'b01, 5'd10, 32'hBB, 0, 0, 1'b1, 5'd10, 5'd10, 5'd9);
    step("bypass_alloc_x10");
    drive('0, 0, 0, 0, 0, 0, 0, 5'd10, 5'd9);
    step("rd_x10");

    for (int i = 0; i < 60; i++) begin
      drive(2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      step("random");
    end

    // Reset mid-run with x5 written and x3 busy
    drive(2'b01, 5'd5, 32'hCAFE, 0, 0, 1'b1, 5'd3, 5'd5, 5'd3);
    step("pre_reset");
    drive('0, 0, 0, 0, 0, 0, 0, 5'd5, 5'd3);
    set_rst(1'b0);
    step("mid_reset");
    set_rst(1'b1);
    run_clear("reclear");
    drive('0, 0, 0, 0, 0, 0, 0, 5'd5, 5'd3);
    step("after_reclear");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
